// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue. It fetches
// sequential words ahead of Decode using a req/gnt/rvalid memory handshake
// with at most one request outstanding. A redirect flushes the queue, and
// any in-flight response is dropped.
module if_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall_ip,
  input  logic                       redirect_valid_ip,
  input  logic [XLEN-1:0]            redirect_pc_ip,
  output logic                       mem_req_op,
  output logic [XLEN-1:0]            mem_addr_op,
  input  logic                       mem_gnt_ip,
  input  logic                       mem_rvalid_ip,
  input  logic [31:0]                mem_rdata_ip,
  output logic                       instr_valid_op,
  output logic [31:0]                instr_data_op,
  output logic [XLEN-1:0]            instr_pc_addr_op,
  output logic [$clog2(DEPTH):0]     occupancy_op
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     qdata_q [DEPTH];
  logic [31:0]     qdata_d [DEPTH];
  logic [XLEN-1:0] qpc_q [DEPTH];
  logic [XLEN-1:0] qpc_d [DEPTH];

  logic issue, grant, push, pop, head_valid;

  // Head outputs, request strobe, and the visible count (all forced quiet during reset)
  always_comb begin
    head_valid       = (count_q != '0);
    issue            = !reset && (state_q == IDLE) && (count_q < CW'(DEPTH));
    mem_req_op       = issue;
    mem_addr_op      = fetch_pc_q;
    instr_valid_op   = !reset && head_valid;
    instr_data_op    = instr_valid_op ? qdata_q[rd_ptr_q] : '0;
    instr_pc_addr_op = instr_valid_op ? qpc_q[rd_ptr_q] : '0;
    occupancy_op     = reset ? '0 : count_q;
  end

  // Next-state for fetch FSM, fetch PC and queue; redirect overrides everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    qdata_d    = qdata_q;
    qpc_d      = qpc_q;

    grant = issue && mem_gnt_ip;
    push  = (state_q == WAIT) && mem_rvalid_ip;
    pop   = head_valid && !stall_ip;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      WAIT:    if (mem_rvalid_ip) state_d = IDLE;
      DROP:    if (mem_rvalid_ip) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_valid_ip) begin
      // A granted or still-pending request belongs to the old path. It must
      // be drained in DROP, not pushed into the queue.
      fetch_pc_d = redirect_pc_ip & ~XLEN'(3);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      unique case (state_q)
        IDLE:    state_d = grant ? DROP : IDLE;
        WAIT:    state_d = mem_rvalid_ip ? IDLE : DROP;
        DROP:    state_d = mem_rvalid_ip ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      if (push) begin
        qdata_d[wr_ptr_q] = mem_rdata_ip;
        qpc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clock) begin
    qdata_q <= qdata_d;
    qpc_q   <= qpc_d;
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue. A randomized memory responder drives
// the DUT. A queue-based reference model predicts the outputs every cycle.
// A second instance checks PC wrap-around with XLEN=8.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT (XLEN=32)
  logic        reset = 1'b1, stall_ip = 1'b0, redirect_valid_ip = 1'b0;
  logic [31:0] redirect_pc_ip = '0;
  logic        mem_req_op, mem_gnt_ip = 1'b0, mem_rvalid_ip = 1'b0;
  logic [31:0] mem_addr_op, mem_rdata_ip = '0;
  logic        instr_valid_op;
  logic [31:0] instr_data_op, instr_pc_addr_op;
  logic [2:0]  occupancy_op;

  if_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall_ip(stall_ip),
    .redirect_valid_ip(redirect_valid_ip), .redirect_pc_ip(redirect_pc_ip),
    .mem_req_op(mem_req_op), .mem_addr_op(mem_addr_op), .mem_gnt_ip(mem_gnt_ip),
    .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip),
    .instr_valid_op(instr_valid_op), .instr_data_op(instr_data_op),
    .instr_pc_addr_op(instr_pc_addr_op), .occupancy_op(occupancy_op)
  );

  // Narrow DUT (XLEN=8, RESET_PC=0xF8)
  logic        reset8 = 1'b1, gnt8 = 1'b0, rvalid8 = 1'b0;
  logic [7:0]  addr8, pc8;
  logic [31:0] rdata8 = '0, data8;
  logic        req8, valid8;
  logic [2:0]  occ8;

  if_prefetch_queue #(.XLEN(8), .DEPTH(DEPTH), .RESET_PC(8'hF8)) dut8 (
    .clock(clock), .reset(reset8), .stall_ip(1'b0),
    .redirect_valid_ip(1'b0), .redirect_pc_ip(8'h00),
    .mem_req_op(req8), .mem_addr_op(addr8), .mem_gnt_ip(gnt8),
    .mem_rvalid_ip(rvalid8), .mem_rdata_ip(rdata8),
    .instr_valid_op(valid8), .instr_data_op(data8),
    .instr_pc_addr_op(pc8), .occupancy_op(occ8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: fetched-but-unconsumed words, next fetch address, and
  // the status of the single outstanding request (0 none, 1 wanted, 2 stale)
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch = '0;
  int          m_inf = 0;
  logic [31:0] m_inf_pc = '0;
  bit          chk_first = 0;
  logic [31:0] first_pc = '0;

  // Memory responder state
  bit          mem_busy = 0;
  logic [31:0] mem_pend = '0;
  int          gcnt = 0, rcnt = 0, gmax = 0, rmax = 0;

  task automatic cycle(input bit rst, input bit stl, input bit rd, input logic [31:0] rpc);
    bit exp_req, g, rv, pop;
    logic [31:0] rdat;
    @(negedge clock);
    reset = rst; stall_ip = stl; redirect_valid_ip = rd; redirect_pc_ip = rpc;
    mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0;
    #1;
    exp_req = (m_inf == 0) && (mq.size() < DEPTH);
    if (rst) begin
      chk("rst_valid", 64'(instr_valid_op), 64'(0));
      chk("rst_data", 64'(instr_data_op), 64'(0));
      chk("rst_pc", 64'(instr_pc_addr_op), 64'(0));
      chk("rst_occ", 64'(occupancy_op), 64'(0));
      chk("rst_req", 64'(mem_req_op), 64'(0));
    end else begin
      chk("valid", 64'(instr_valid_op), 64'(mq.size() != 0));
      chk("data", 64'(instr_data_op), 64'(mq.size() != 0 ? mq[0].data : 32'h0));
      chk("pc", 64'(instr_pc_addr_op), 64'(mq.size() != 0 ? mq[0].pc : 32'h0));
      chk("occ", 64'(occupancy_op), 64'(mq.size()));
      chk("req", 64'(mem_req_op), 64'(exp_req));
      if (mem_req_op) chk("addr", 64'(mem_addr_op), 64'(m_fetch));
      if (chk_first && instr_valid_op) begin
        chk("first_after_redirect", 64'(instr_pc_addr_op), 64'(first_pc));
        chk_first = 0;
      end
    end
    // memory: answer an earlier grant, then possibly grant the current request
    rv = 0; rdat = '0;
    if (mem_busy) begin
      if (rcnt == 0) begin rv = 1; rdat = imem(mem_pend); mem_busy = 0; end
      else rcnt--;
    end
    g = 0;
    if (mem_req_op && !mem_busy) begin
      if (gcnt == 0) begin
        g = 1; mem_busy = 1; mem_pend = mem_addr_op;
        rcnt = int'($urandom_range(rmax, 0));
        gcnt = int'($urandom_range(gmax, 0));
      end else gcnt--;
    end
    mem_gnt_ip = g; mem_rvalid_ip = rv; mem_rdata_ip = rv ? rdat : $urandom;
    // reference model update for the coming edge
    if (rst) begin
      m_fetch = 32'h0; mq.delete(); m_inf = 0; chk_first = 0;
    end else begin
      pop = (mq.size() != 0) && !stl;
      if (rd) begin
        mq.delete();
        m_fetch = rpc & ~32'h3;
        if (m_inf != 0) m_inf = rv ? 0 : 2;
        else            m_inf = (exp_req && g) ? 2 : 0;
        chk_first = 1; first_pc = rpc & ~32'h3;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_inf == 1 && rv) begin
          mq.push_back('{pc: m_inf_pc, data: rdat}); m_inf = 0;
        end else if (m_inf == 2 && rv) begin
          m_inf = 0;
        end else if (m_inf == 0 && exp_req && g) begin
          m_inf = 1; m_inf_pc = m_fetch; m_fetch = m_fetch + 32'd4;
        end
      end
    end
  endtask

  // condition selectors for directed redirect points
  function automatic bit at_point(input int kind);
    case (kind)
      0: return (m_inf == 1) && !(mem_busy && rcnt == 0);     // WAIT, no rvalid next
      1: return (m_inf == 0) && (mq.size() < DEPTH);          // grant next
      2: return (m_inf == 1) && mem_busy && (rcnt == 0);      // rvalid next
      default: return mq.size() != 0;                         // head present
    endcase
  endfunction

  task automatic redirect_at(input int kind, input bit stl, input logic [31:0] target);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (at_point(kind)) hit = 1;
      else cycle(0, 0, 0, 32'h0);
    end
    chk("reach_point", 64'(hit), 64'(1));
    cycle(0, stl, 1, target);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 32'h0);
  endtask

  initial begin
    int n8, nreq8;
    bit busy8;
    logic [7:0] pend8;
    logic [7:0] exp8 [3];

    // reset, then zero-wait memory without stall
    repeat (3) cycle(1, 0, 0, 32'h0);
    gmax = 0; rmax = 0;
    repeat (20) cycle(0, 0, 0, 32'h0);

    // long stall from a fresh reset: queue fills, head held at PC 0
    repeat (2) cycle(1, 0, 0, 32'h0);
    repeat (20) cycle(0, 1, 0, 32'h0);
    chk("full_occ", 64'(occupancy_op), 64'(DEPTH));
    chk("full_noreq", 64'(mem_req_op), 64'(0));
    chk("full_head", 64'(instr_pc_addr_op), 64'(0));
    repeat (15) cycle(0, 0, 0, 32'h0);

    // directed redirects
    gmax = 0; rmax = 2;
    redirect_at(0, 0, 32'h104);
    redirect_at(0, 0, 32'h107);
    gmax = 0; rmax = 0;
    redirect_at(1, 0, 32'h200);
    redirect_at(2, 0, 32'h300);
    redirect_at(3, 1, 32'h400);

    // randomized delays, stalls, redirects and occasional mid-flight resets
    gmax = 5; rmax = 5;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 250) == 0, ($urandom % 3) == 0,
            ($urandom % 40) == 0, $urandom);
    end

    // XLEN=8 wrap-around with a zero-wait memory
    exp8[0] = 8'hF8; exp8[1] = 8'hFC; exp8[2] = 8'h00;
    n8 = 0; nreq8 = 0; busy8 = 0; pend8 = '0;
    for (int i = 0; i < 40 && n8 < 3; i++) begin
      @(negedge clock);
      reset8 = 1'b0; gnt8 = 1'b0; rvalid8 = 1'b0;
      #1;
      if (valid8) begin
        chk("x8_pc", 64'(pc8), 64'(exp8[n8]));
        chk("x8_data", 64'(data8), 64'(imem({24'h0, exp8[n8]})));
        n8++;
      end
      if (busy8) begin rvalid8 = 1'b1; rdata8 = imem({24'h0, pend8}); busy8 = 0; end
      if (req8) begin
        if (nreq8 < 3) chk("x8_addr", 64'(addr8), 64'(exp8[nreq8]));
        nreq8++;
        gnt8 = 1'b1; busy8 = 1; pend8 = addr8;
      end
    end
    chk("x8_count", 64'(n8), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
